// File: rtl/pattern_checker.sv
// rtl/pattern_checker.sv - receive-side pattern checker; optional first-error capture under PATTERN_CHECK_FIRST_ERR_EN
module pattern_checker #(
    parameter int LINE_LEN     = 1290,
    parameter int REG_LINE_LEN = 4096,
    parameter int LINES        = 24,
    parameter int START_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_sync,
    input  logic        sync,
    input  logic [2:0]  Mode,
    input  logic [11:0] constVal,
    input  logic [1:0]  X,
    input  logic [1:0]  Y,
    input  logic [11:0] data_in,
    output logic        busy,
    output logic        line_err,
    output logic        frame_done,
    output logic        frame_pass,
    output logic [15:0] err_cnt,
    output logic [4:0]  first_err_line,
    output logic [11:0] first_err_pix
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LAT   = 2'd1,
        S_CHECK = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    // Last pixel index for the Gray-count mode and for all other modes.
    localparam logic [11:0] REG_LAST  = 12'(REG_LINE_LEN - 1);
    localparam logic [11:0] PIX_LAST  = 12'(LINE_LEN - 1);
    localparam logic [4:0]  LINE_LAST = 5'(LINES - 1);
    // LAT holds for START_LAT-1 cycles; the counter is loaded with one less
    // so that a zero count means "leave LAT this cycle".
    localparam logic [2:0]  LAT_INIT  = 3'((START_LAT > 1) ? (START_LAT - 2) : 0);
    localparam bit          SKIP_LAT  = (START_LAT <= 1);

    state_t      state;
    state_t      state_nxt;

    // Frame configuration, frozen at frame start.
    logic [2:0]  mode_q;
    logic [11:0] const_q;
    logic [11:0] dx_q;
    logic [11:0] dy_q;

    // Position within the frame and the ramp accumulators.
    logic [11:0] pix;
    logic [4:0]  line;
    logic [2:0]  lat_cnt;
    logic [11:0] line_acc;
    logic [11:0] pix_acc;

    logic        line_flag;
    logic        frame_start;
    logic        line_start;
    logic        checking;
    logic        last_pix;
    logic        last_line;
    logic        frame_end;
    logic        mismatch;
    logic [11:0] last_idx;
    logic [11:0] expected;
    logic [11:0] dx_sel;
    logic [11:0] dy_sel;
    logic        err_sat;

    // Frame and line event decode.
    always_comb begin
        frame_start = (state == S_IDLE) && f_sync && sync && (Mode != 3'd0);
        line_start  = (state == S_GAP) && sync;
        checking    = (state == S_CHECK);
        last_idx    = (mode_q == 3'd1) ? REG_LAST : PIX_LAST;
        last_pix    = checking && (pix == last_idx);
        last_line   = (line == LINE_LAST);
        frame_end   = last_pix && last_line;
        mismatch    = checking && (data_in != expected);
        err_sat     = (err_cnt == 16'hFFFF);
    end

    // Ramp step decode from the X/Y select inputs.
    always_comb begin
        dx_sel = 12'd0;
        dy_sel = 12'd0;
        case (X)
            2'd0: dx_sel = 12'd0;
            2'd1: dx_sel = 12'd1;
            2'd2: dx_sel = 12'd4;
            default: dx_sel = 12'd8;
        endcase
        case (Y)
            2'd0: dy_sel = 12'd0;
            2'd1: dy_sel = 12'd1;
            2'd2: dy_sel = 12'd16;
            default: dy_sel = 12'd1290;
        endcase
    end

    // Regenerate the expected pixel for the current (pix, line) position.
    always_comb begin
        expected = 12'd0;
        case (mode_q)
            3'd1: expected = pix ^ {1'b0, pix[11:1]};
            3'd2: expected = const_q;
            // (p+l) is odd exactly when the LSBs differ.
            3'd3: expected = {12{pix[0] ^ line[0]}};
            3'd4: expected = ~{12{pix[0] ^ line[0]}};
            // ((p>>1)+(l>>1)) is odd exactly when bit 1 of p and l differ.
            3'd5: expected = {12{pix[1] ^ line[1]}};
            3'd6: expected = ~{12{pix[1] ^ line[1]}};
            3'd7: expected = pix_acc;
            default: expected = 12'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; sync is only honoured in IDLE (with f_sync) and GAP.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    state_nxt = SKIP_LAT ? S_CHECK : S_LAT;
                end
            end
            S_LAT: begin
                if (lat_cnt == 3'd0) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (last_pix) begin
                    state_nxt = last_line ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (sync) begin
                    state_nxt = SKIP_LAT ? S_CHECK : S_LAT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latch the pattern configuration at frame start only.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= 3'd0;
            const_q <= 12'd0;
            dx_q    <= 12'd0;
            dy_q    <= 12'd0;
        end else if (frame_start) begin
            mode_q  <= Mode;
            const_q <= constVal;
            dx_q    <= dx_sel;
            dy_q    <= dy_sel;
        end
    end

    // Latency countdown between a line start and pixel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= 3'd0;
        end else if (frame_start || line_start) begin
            lat_cnt <= LAT_INIT;
        end else if ((state == S_LAT) && (lat_cnt != 3'd0)) begin
            lat_cnt <= lat_cnt - 3'd1;
        end
    end

    // Pixel and line position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix  <= 12'd0;
            line <= 5'd0;
        end else begin
            if (frame_start || last_pix) begin
                pix <= 12'd0;
            end else if (checking) begin
                pix <= pix + 12'd1;
            end
            if (frame_start) begin
                line <= 5'd0;
            end else if (last_pix && !last_line) begin
                line <= line + 5'd1;
            end
        end
    end

    // Ramp accumulators: dY per line into line_acc, dX per pixel into pix_acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_acc <= 12'd0;
            pix_acc  <= 12'd0;
        end else begin
            if (frame_start) begin
                line_acc <= 12'd0;
            end else if (last_pix) begin
                line_acc <= line_acc + dy_q;
            end
            if (frame_start) begin
                pix_acc <= 12'd0;
            end else if (line_start) begin
                pix_acc <= line_acc;
            end else if (checking) begin
                pix_acc <= pix_acc + dx_q;
            end
        end
    end

    // Mismatch counting and the per-line sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt   <= 16'd0;
            line_flag <= 1'b0;
        end else begin
            if (frame_start) begin
                err_cnt <= 16'd0;
            end else if (mismatch && !err_sat) begin
                err_cnt <= err_cnt + 16'd1;
            end
            if (frame_start || last_pix) begin
                line_flag <= 1'b0;
            end else if (mismatch) begin
                line_flag <= 1'b1;
            end
        end
    end

    // Registered status: line/frame pulses, pass flag and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_err   <= 1'b0;
            frame_done <= 1'b0;
            frame_pass <= 1'b0;
            busy       <= 1'b0;
        end else begin
            line_err   <= last_pix && (line_flag || mismatch);
            frame_done <= frame_end;
            if (frame_end) begin
                // The final pixel has not reached err_cnt yet, so fold it in here.
                frame_pass <= (err_cnt == 16'd0) && !mismatch;
            end
            busy <= (state_nxt != S_IDLE) || frame_end;
        end
    end

`ifdef PATTERN_CHECK_FIRST_ERR_EN
    // Capture the position of the first mismatch of the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_line <= 5'd0;
            first_err_pix  <= 12'd0;
        end else if (frame_start) begin
            first_err_line <= 5'd0;
            first_err_pix  <= 12'd0;
        end else if (mismatch && (err_cnt == 16'd0)) begin
            first_err_line <= line;
            first_err_pix  <= pix;
        end
    end
`else
    assign first_err_line = 5'd0;
    assign first_err_pix  = 12'd0;
`endif

endmodule
